lite_reg_slave: RTL and testbench

AXI4-Lite responder holding the DMA controller's control/status register bank. It answers the read transactions issued by the AXI-Lite read master and services write transactions on the same bus. It drives the DMA core's configuration (source address, destination address, length) and its start pulse, and reports the core's idle status back on the bus.

---
 rtl/lite_reg_slave.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_lite_reg_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lite_reg_slave.sv
// lite_reg_slave: AXI4-Lite responder for the DMA controller register bank.
// Holds SRC/DST/LEN/SCRATCH, produces the one-cycle dma_start pulse from CTRL
// writes, and reports the live dma_idle status. Read and write channels run
// as two independent two-state FSMs.
//
// Write FSM
//   state   | meaning
//   WR_IDLE | collecting AW and W in any order; commit once both are held
//   WR_RESP | bvalid asserted with a stable bresp, waiting for bready
//
// Read FSM
//   state   | meaning
//   RD_IDLE | arready high, read data captured on the AR handshake
//   RD_DATA | rvalid asserted with stable rdata/rresp, waiting for rready
module lite_reg_slave #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
  input  logic              s_axi_lite_awvalid,
  output logic              s_axi_lite_awready,
  input  logic [DATA_W-1:0] s_axi_lite_wdata,
  input  logic [3:0]        s_axi_lite_wstrb,
  input  logic              s_axi_lite_wvalid,
  output logic              s_axi_lite_wready,
  output logic [1:0]        s_axi_lite_bresp,
  output logic              s_axi_lite_bvalid,
  input  logic              s_axi_lite_bready,
  input  logic [ADDR_W-1:0] s_axi_lite_araddr,
  input  logic              s_axi_lite_arvalid,
  output logic              s_axi_lite_arready,
  output logic [DATA_W-1:0] s_axi_lite_rdata,
  output logic [1:0]        s_axi_lite_rresp,
  output logic              s_axi_lite_rvalid,
  input  logic              s_axi_lite_rready,
  input  logic              dma_idle,
  output logic              dma_start,
  output logic [DATA_W-1:0] src_addr,
  output logic [DATA_W-1:0] dst_addr,
  output logic [DATA_W-1:0] xfer_len
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_STATUS  = 3'd1;
  localparam logic [2:0] IDX_SRC     = 3'd2;
  localparam logic [2:0] IDX_DST     = 3'd3;
  localparam logic [2:0] IDX_LEN     = 3'd4;
  localparam logic [2:0] IDX_SCRATCH = 3'd5;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [3:0]        strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Word addresses above the six-register window, or with any high bit set,
  // are unmapped.
  function automatic logic addr_mapped(input logic [ADDR_W-1:2] word_addr);
    return (word_addr[ADDR_W-1:5] == '0) && (word_addr[4:2] <= IDX_SCRATCH);
  endfunction

  // ---------------------------------------------------------------------
  // Register bank storage
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_src;
  logic [DATA_W-1:0] r_dst;
  logic [DATA_W-1:0] r_len;
  logic [DATA_W-1:0] r_scratch;
  logic              r_dma_start;

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  wr_state_t         r_wr_state;
  wr_state_t         w_wr_next;
  logic              r_aw_held;
  logic              r_w_held;
  logic [ADDR_W-1:2] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic              w_wr_done;
  logic [2:0]        w_wr_idx;
  logic              w_wr_mapped;
  logic              w_start_req;
  logic              w_fire_start;
  logic [1:0]        w_wr_resp;

  assign w_aw_hs   = s_axi_lite_awvalid & s_axi_lite_awready;
  assign w_w_hs    = s_axi_lite_wvalid & s_axi_lite_wready;
  assign w_commit  = (r_wr_state == WR_IDLE) & r_aw_held & r_w_held;
  assign w_wr_done = (r_wr_state == WR_RESP) & s_axi_lite_bready;

  assign w_wr_idx     = r_awaddr[4:2];
  assign w_wr_mapped  = addr_mapped(r_awaddr);
  assign w_start_req  = w_wr_mapped & (w_wr_idx == IDX_CTRL) & r_wdata[0] & r_wstrb[0];
  assign w_fire_start = w_commit & w_start_req & dma_idle;

  // A start request while the core is busy is refused with SLVERR; all other
  // mapped writes (including ignored STATUS writes) answer OKAY.
  always_comb begin
    w_wr_resp = RESP_OKAY;
    if (!w_wr_mapped) begin
      w_wr_resp = RESP_SLVERR;
    end else if (w_start_req && !dma_idle) begin
      w_wr_resp = RESP_SLVERR;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_state <= WR_IDLE;
    else     r_wr_state <= w_wr_next;
  end

  // Write FSM next-state logic.
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_commit)           w_wr_next = WR_RESP;
      WR_RESP: if (s_axi_lite_bready)  w_wr_next = WR_IDLE;
      default:                         w_wr_next = WR_IDLE;
    endcase
  end

  // Write FSM outputs: each ready drops as soon as its channel is captured.
  always_comb begin
    s_axi_lite_awready = 1'b0;
    s_axi_lite_wready  = 1'b0;
    s_axi_lite_bvalid  = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        s_axi_lite_awready = ~r_aw_held;
        s_axi_lite_wready  = ~r_w_held;
      end
      WR_RESP: s_axi_lite_bvalid = 1'b1;
      default: ;
    endcase
  end

  // Capture AW and W independently; both flags are released together once
  // the response has been accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_wr_done) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_lite_awaddr[ADDR_W-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_lite_wdata;
        r_wstrb  <= s_axi_lite_wstrb;
      end
    end
  end

  // Latch the write response on the commit edge so it stays stable under
  // back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_bresp <= RESP_OKAY;
    else if (w_commit) r_bresp <= w_wr_resp;
  end

  // Start pulse lines up with the first bvalid cycle and self-clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dma_start <= 1'b0;
    else     r_dma_start <= w_fire_start;
  end

  // Commit byte-enabled writes to the RW registers; busy status never
  // blocks configuration updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_scratch <= '0;
    end else if (w_commit && w_wr_mapped) begin
      case (w_wr_idx)
        IDX_SRC:     r_src     <= merge_bytes(r_src, r_wdata, r_wstrb);
        IDX_DST:     r_dst     <= merge_bytes(r_dst, r_wdata, r_wstrb);
        IDX_LEN:     r_len     <= merge_bytes(r_len, r_wdata, r_wstrb);
        IDX_SCRATCH: r_scratch <= merge_bytes(r_scratch, r_wdata, r_wstrb);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  rd_state_t         r_rd_state;
  rd_state_t         w_rd_next;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_ar_hs;
  logic [2:0]        w_rd_idx;
  logic              w_rd_mapped;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        w_rd_resp;

  assign w_ar_hs     = s_axi_lite_arvalid & s_axi_lite_arready;
  assign w_rd_idx    = s_axi_lite_araddr[4:2];
  assign w_rd_mapped = addr_mapped(s_axi_lite_araddr[ADDR_W-1:2]);

  // Read decode works on pre-commit register values, so a read and a write
  // to the same register on one edge returns the old contents.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (!w_rd_mapped) begin
      w_rd_resp = RESP_SLVERR;
    end else begin
      case (w_rd_idx)
        IDX_STATUS:  w_rd_data = {{(DATA_W-1){1'b0}}, dma_idle};
        IDX_SRC:     w_rd_data = r_src;
        IDX_DST:     w_rd_data = r_dst;
        IDX_LEN:     w_rd_data = r_len;
        IDX_SCRATCH: w_rd_data = r_scratch;
        default:     w_rd_data = '0;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_state <= RD_IDLE;
    else     r_rd_state <= w_rd_next;
  end

  // Read FSM next-state logic.
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (s_axi_lite_arvalid) w_rd_next = RD_DATA;
      RD_DATA: if (s_axi_lite_rready)  w_rd_next = RD_IDLE;
      default:                         w_rd_next = RD_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    s_axi_lite_arready = 1'b0;
    s_axi_lite_rvalid  = 1'b0;
    case (r_rd_state)
      RD_IDLE: s_axi_lite_arready = 1'b1;
      RD_DATA: s_axi_lite_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Register the read payload on the AR handshake; it holds through RD_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_resp;
    end
  end

  assign s_axi_lite_bresp = r_bresp;
  assign s_axi_lite_rdata = r_rdata;
  assign s_axi_lite_rresp = r_rresp;
  assign dma_start        = r_dma_start;
  assign src_addr         = r_src;
  assign dst_addr         = r_dst;
  assign xfer_len         = r_len;

endmodule

// File: tb/tb_lite_reg_slave.sv
// Directed bench for lite_reg_slave: expected write responses and read
// results are queued when a transaction is issued and popped when the DUT
// presents the response.
module tb_lite_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [9:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        dma_idle;
  logic        dma_start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] xfer_len;

  int checks = 0;
  int errors = 0;

  logic [33:0] rd_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] m_reg[6];

  lite_reg_slave #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .dma_idle(dma_idle), .dma_start(dma_start),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [9:0] addr,
                         input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n = 0;
    logic [33:0] e;
    rd_q.push_back({exp_r, exp_d});
    araddr  = addr;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ar_wait"}, 32'(n < 20), 32'd1);
    tick();
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    e = rd_q.pop_front();
    chk({tag, "_rdata"}, rdata, e[31:0]);
    chk({tag, "_rresp"}, 32'(rresp), 32'(e[33:32]));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 32'(rvalid), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] exp_resp, input logic exp_start);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    int cyc = 0;
    int idx;
    b_q.push_back(exp_resp);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (aw_done && !w_done) chk({tag, "_awready_held"}, 32'(awready), 32'd0);
      if (w_done && !aw_done) chk({tag, "_wready_held"}, 32'(wready), 32'd0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk({tag, "_capture_wait"}, 32'(cyc < 50), 32'd1);
    chk({tag, "_bvalid_early"}, 32'(bvalid), 32'd0);
    chk({tag, "_start_early"}, 32'(dma_start), 32'd0);
    tick();
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_start"}, 32'(dma_start), 32'(exp_start));
    chk({tag, "_bresp"}, 32'(bresp), 32'(b_q.pop_front()));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 32'(bvalid), 32'd0);
    chk({tag, "_start_clr"}, 32'(dma_start), 32'd0);
    idx = int'(addr[4:2]);
    if (exp_resp == 2'b00 && addr[9:5] == 5'd0 && idx >= 2 && idx <= 5) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_reg[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 2; i <= 5; i++)
      do_read(tag, 10'(4 * i), m_reg[i], 2'b00);
    chk({tag, "_src_out"}, src_addr, m_reg[2]);
    chk({tag, "_dst_out"}, dst_addr, m_reg[3]);
    chk({tag, "_len_out"}, xfer_len, m_reg[4]);
  endtask

  initial begin
    logic [33:0] e;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; dma_idle = 1'b1;
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_start", 32'(dma_start), 32'd0);
    chk("rst_src", src_addr, 32'd0);
    chk("rst_dst", dst_addr, 32'd0);
    chk("rst_len", xfer_len, 32'd0);

    do_read("rd_src0", 10'h08, 32'h0, 2'b00);
    do_read("rd_dst0", 10'h0C, 32'h0, 2'b00);
    do_read("rd_len0", 10'h10, 32'h0, 2'b00);
    do_read("rd_scr0", 10'h14, 32'h0, 2'b00);
    do_read("rd_ctrl0", 10'h00, 32'h0, 2'b00);
    do_read("rd_stat_idle", 10'h04, 32'h1, 2'b00);
    dma_idle = 1'b0;
    do_read("rd_stat_busy", 10'h04, 32'h0, 2'b00);
    dma_idle = 1'b1;

    // write ordering: AW first, then W well before AW
    do_write("wr_src_awfirst", 10'h08, 32'hFFFF_0000, 4'hF, 0, 1, 2'b00, 1'b0);
    do_read("rd_src_a", 10'h08, 32'hFFFF_0000, 2'b00);
    do_write("wr_src_wfirst", 10'h08, 32'h1234_5678, 4'hF, 3, 0, 2'b00, 1'b0);
    do_read("rd_src_b", 10'h08, 32'h1234_5678, 2'b00);
    chk("src_out", src_addr, 32'h1234_5678);

    // byte enables, AW and W together
    do_write("wr_scr_strb", 10'h14, 32'hAABB_CCDD, 4'b0101, 0, 0, 2'b00, 1'b0);
    do_read("rd_scr_strb", 10'h14, 32'h00BB_00DD, 2'b00);

    // start pulse, idle and busy
    do_write("wr_ctrl_idle", 10'h00, 32'h1, 4'h1, 0, 0, 2'b00, 1'b1);
    do_read("rd_ctrl", 10'h00, 32'h0, 2'b00);
    dma_idle = 1'b0;
    do_write("wr_ctrl_busy", 10'h00, 32'h1, 4'hF, 0, 0, 2'b10, 1'b0);
    do_write("wr_dst_busy", 10'h0C, 32'hCAFE_F00D, 4'hF, 1, 0, 2'b00, 1'b0);
    chk("dst_out_busy", dst_addr, 32'hCAFE_F00D);
    dma_idle = 1'b1;
    do_write("wr_status", 10'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, 1'b0);
    do_write("wr_len", 10'h10, 32'h0000_0100, 4'hF, 0, 0, 2'b00, 1'b0);

    // unmapped addresses
    do_write("wr_unmapped", 10'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 1'b0);
    do_read("rd_unmapped", 10'h1C, 32'h0, 2'b10);
    do_write("wr_hi_addr", 10'h208, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 1'b0);
    do_read("rd_hi_addr", 10'h208, 32'h0, 2'b10);
    check_bank("bank_after_err");

    // read/write collision on LEN with read back-pressure
    b_q.push_back(2'b00);
    rd_q.push_back({2'b00, 32'h0000_0100});
    awaddr = 10'h10; wdata = 32'h0000_0200; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 10'h10; arvalid = 1'b1;
    chk("col_arready_pre", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    e = rd_q.pop_front();
    chk("col_bvalid", 32'(bvalid), 32'd1);
    chk("col_bresp", 32'(bresp), 32'(b_q.pop_front()));
    chk("col_rvalid", 32'(rvalid), 32'd1);
    chk("col_rdata_old", rdata, e[31:0]);
    chk("col_len_out", xfer_len, 32'h0000_0200);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("col_rvalid_hold", 32'(rvalid), 32'd1);
      chk("col_rdata_hold", rdata, e[31:0]);
      chk("col_arready_hold", 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("col_rvalid_clr", 32'(rvalid), 32'd0);
    chk("col_arready_back", 32'(arready), 32'd1);
    m_reg[4] = 32'h0000_0200;
    do_read("rd_len_new", 10'h10, 32'h0000_0200, 2'b00);

    // reset in the middle of a write
    awaddr = 10'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid_awready_low", 32'(awready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_awready_rst", 32'(awready), 32'd1);
    chk("mid_wready_rst", 32'(wready), 32'd1);
    chk("mid_src_rst", src_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (2) tick();
    chk("mid_no_commit_bvalid", 32'(bvalid), 32'd0);
    chk("mid_wready_held", 32'(wready), 32'd0);
    awaddr = 10'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    chk("mid_late_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    m_reg[5] = 32'hDEAD_BEEF;
    check_bank("bank_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
